multicycle_ctrl: RTL and testbench

- Moore-style control FSM for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for LW, SW, ADDI, R-type (ADD/SUB/AND/OR/SLT), BEQ, J and JAL.
- Drives the ALU operation select, using the team's ALU encoding, plus all datapath mux, enable and memory strobes.
- Waits on a memory ready handshake; flags illegal instructions.

---
 rtl/multicycle_ctrl_if.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multi-cycle MIPS controller
// and its datapath.
//   master (controller): receives op, funct, zero, mem_ready; drives every
//                        memory strobe, mux select, enable and ALU select.
//   slave  (datapath)  : the mirror image of master.
// Parameters: OP_W  opcode/funct width, SEL_W  ALU select width.
interface multicycle_ctrl_if #(
  parameter int OP_W  = 6,
  parameter int SEL_W = 3
) ();
  logic [OP_W-1:0]  op;
  logic [OP_W-1:0]  funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [SEL_W-1:0] alu_sel;
  logic             illegal_op;
  logic             busy;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel,
           illegal_op, busy
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel,
           illegal_op, busy
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback for LW, SW, ADDI,
// R-type (ADD/SUB/AND/OR/SLT), BEQ, J and JAL; flags illegal instructions.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (forces IDLE, all outputs 0)
//   bus        multicycle_ctrl_if.master (datapath inputs and control outputs)
//   cyc_cnt    busy-cycle counter          (MULTICYCLE_CTRL_PERF_EN only)
//   instr_cnt  retired-instruction counter (MULTICYCLE_CTRL_PERF_EN only)
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN (adds the two counters).
module multicycle_ctrl #(
  parameter int OP_W  = 6,
  parameter int SEL_W = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  multicycle_ctrl_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(32);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(34);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(36);
  localparam logic [OP_W-1:0] FN_OR  = OP_W'(37);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(42);

  localparam logic [SEL_W-1:0] SEL_ERR = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_SUB = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_AND = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_OR  = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_SLT = SEL_W'(5);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE_EX, S_RTYPE_WB, S_ADDI_EX, S_ADDI_WB, S_BEQ_EX, S_JUMP,
    S_JAL, S_ILLEGAL
  } state_t;

  // Registered control word. fetch/beq are state flags used to qualify the
  // two strobes that also depend on live datapath inputs.
  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [SEL_W-1:0] alu_sel;
    logic             illegal_op;
    logic             busy;
    logic             fetch;
    logic             beq;
  } ctrl_t;

  state_t st, nxt;
  ctrl_t  ctl;

  function automatic logic [SEL_W-1:0] rtype_sel(input logic [OP_W-1:0] f);
    case (f)
      FN_ADD:  return SEL_ADD;
      FN_SUB:  return SEL_SUB;
      FN_AND:  return SEL_AND;
      FN_OR:   return SEL_OR;
      FN_SLT:  return SEL_SLT;
      default: return SEL_ERR;
    endcase
  endfunction

  // Control word for a state; evaluated on the next state so that the
  // registered outputs line up with the state register.
  function automatic ctrl_t decode(input state_t s, input logic [OP_W-1:0] f);
    ctrl_t c;
    c      = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
        c.alu_sel   = SEL_ADD;
        c.fetch     = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'd3;
        c.alu_sel   = SEL_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_sel   = SEL_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'd1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_sel   = rtype_sel(f);
      end
      S_RTYPE_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'd1;
      end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_BEQ_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_sel   = SEL_SUB;
        c.pc_src    = 2'd1;
        c.beq       = 1'b1;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'd2;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_src     = 2'd2;
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'd2;
        c.mem_to_reg = 2'd2;
      end
      S_ILLEGAL: c.illegal_op = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = S_IDLE;
    case (st)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_ADDI:      nxt = S_ADDI_EX;
          OP_RTYPE:     nxt = (rtype_sel(bus.funct) != SEL_ERR) ? S_RTYPE_EX : S_ILLEGAL;
          OP_BEQ:       nxt = S_BEQ_EX;
          OP_J:         nxt = S_JUMP;
          OP_JAL:       nxt = S_JAL;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWR:    nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: nxt = S_RTYPE_WB;
      S_RTYPE_WB: nxt = S_FETCH;
      S_ADDI_EX:  nxt = S_ADDI_WB;
      S_ADDI_WB:  nxt = S_FETCH;
      S_BEQ_EX, S_JUMP, S_JAL, S_ILLEGAL: nxt = S_FETCH;
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= S_IDLE;
      ctl <= '0;
`ifdef MULTICYCLE_CTRL_PERF_EN
      cyc_cnt   <= '0;
      instr_cnt <= '0;
`endif
    end else begin
      st  <= nxt;
      ctl <= decode(nxt, bus.funct);
`ifdef MULTICYCLE_CTRL_PERF_EN
      if (ctl.busy)
        cyc_cnt <= cyc_cnt + 1'b1;
      if (nxt == S_FETCH && st != S_IDLE && st != S_FETCH)
        instr_cnt <= instr_cnt + 1'b1;
`endif
    end
  end

  assign bus.mem_read   = ctl.mem_read;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.i_or_d     = ctl.i_or_d;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_sel    = ctl.alu_sel;
  assign bus.illegal_op = ctl.illegal_op;
  assign bus.busy       = ctl.busy;
  // Fetch completes, and a taken branch commits, in the same cycle as the
  // qualifying input, so these two strobes cannot be pre-registered.
  assign bus.ir_write   = ctl.fetch & bus.mem_ready;
  assign bus.pc_write   = ctl.pc_write | (ctl.fetch & bus.mem_ready) | (ctl.beq & bus.zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven checks of multicycle_ctrl. Each table row
// is one instruction: its op/funct/zero, the expected state letter per cycle
// and the mem_ready value driven in that cycle. Every cycle's full output
// word is compared against the expected per-state control word.
// State letters: I idle, F fetch, D decode, A memadr, R memrd, B memwb,
// W memwr, X rtype_ex, Y rtype_wb, P addi_ex, Q addi_wb, E beq_ex, J jump,
// L jal, Z illegal.
// Define MULTICYCLE_CTRL_PERF_EN to also check the performance counters.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl_if #(.OP_W(6), .SEL_W(3)) bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] instr_cnt;
`endif

  multicycle_ctrl #(.OP_W(6), .SEL_W(3), .CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cyc_cnt(cyc_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  // {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, reg_write,
  //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel, illegal_op, busy}
  logic [19:0] act;
  assign act = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.illegal_op, bus.busy};

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] sel;
    string      st;
    string      mr;
  } vec_t;

  vec_t v[15];

  task automatic setv(input int i, input int op, input int funct, input logic z,
                      input int sel, input string st, input string mr);
    v[i].op = 6'(op);
    v[i].funct = 6'(funct);
    v[i].zero = z;
    v[i].sel = 3'(sel);
    v[i].st = st;
    v[i].mr = mr;
  endtask

  function automatic logic [19:0] exp_out(input byte s, input logic mr, input logic z,
                                          input logic [2:0] rsel);
    logic rd = 0, wr = 0, iod = 0, irw = 0, pcw = 0, rw = 0, a = 0, ill = 0, bz = 1;
    logic [1:0] pcs = 0, rdst = 0, m2r = 0, b = 0;
    logic [2:0] sel = 0;
    case (s)
      "I": bz = 0;
      "F": begin rd = 1; b = 1; sel = 1; irw = mr; pcw = mr; end
      "D": begin b = 3; sel = 1; end
      "A", "P": begin a = 1; b = 2; sel = 1; end
      "R": begin rd = 1; iod = 1; end
      "B": begin rw = 1; m2r = 1; end
      "W": begin wr = 1; iod = 1; end
      "X": begin a = 1; sel = rsel; end
      "Y": begin rw = 1; rdst = 1; end
      "Q": rw = 1;
      "E": begin a = 1; sel = 2; pcs = 1; pcw = z; end
      "J": begin pcw = 1; pcs = 2; end
      "L": begin pcw = 1; pcs = 2; rw = 1; rdst = 2; m2r = 2; end
      "Z": ill = 1;
      default: ;
    endcase
    return {rd, wr, iod, irw, pcw, pcs, rw, rdst, m2r, a, b, sel, ill, bz};
  endfunction

  task automatic check_out(input string name, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s outputs got=%05h expected=%05h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Entered #1 after a rising edge with the DUT in FETCH; leaves the same
  // way after the instruction's last cycle.
  task automatic run_vec(input int i);
    for (int k = 0; k < v[i].st.len(); k++) begin
      bus.op = v[i].op;
      bus.funct = v[i].funct;
      bus.zero = v[i].zero;
      bus.mem_ready = (v[i].mr[k] == "1");
      #1;
      check_out($sformatf("vec%0d_cyc%0d_%s", i, k, string'(v[i].st[k])),
                exp_out(v[i].st[k], bus.mem_ready, v[i].zero, v[i].sel));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    setv(0,  0, 32, 1'b0, 1, "FDXY", "1011");       // ADD; mem_ready ignored in DECODE
    setv(1,  35, 0, 1'b0, 0, "FFFDARRRRB", "0011100011"); // LW with waits, 10 cycles
    setv(2,  4, 0, 1'b1, 0, "FDE", "111");           // BEQ taken
    setv(3,  4, 0, 1'b0, 0, "FDE", "110");           // BEQ not taken
    setv(4,  3, 0, 1'b1, 0, "FDL", "111");           // JAL
    setv(5,  13, 0, 1'b0, 0, "FDZ", "111");          // undefined opcode
    setv(6,  0, 34, 1'b0, 2, "FDXY", "1111");        // SUB
    setv(7,  0, 36, 1'b0, 3, "FDXY", "1111");        // AND
    setv(8,  0, 37, 1'b0, 4, "FDXY", "1111");        // OR
    setv(9,  0, 42, 1'b0, 5, "FDXY", "1111");        // SLT
    setv(10, 0, 7, 1'b0, 0, "FDZ", "111");           // bad funct
    setv(11, 8, 0, 1'b0, 0, "FDPQ", "1111");         // ADDI
    setv(12, 43, 0, 1'b0, 0, "FDAW", "1111");        // SW
    setv(13, 43, 0, 1'b0, 0, "FDAWW", "11101");      // SW with one wait
    setv(14, 2, 0, 1'b0, 0, "FDJ", "111");           // J

    bus.op = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_outputs", exp_out("I", 1'b0, 1'b0, 3'd0));
    bus.mem_ready = 1'b1;
    #1;
    check_out("reset_outputs_mem_ready", exp_out("I", 1'b1, 1'b0, 3'd0));
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_val("reset_cyc_cnt", cyc_cnt, 32'd0);
    check_val("reset_instr_cnt", instr_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_out("idle_after_release", exp_out("I", 1'b1, 1'b0, 3'd0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(i);
    bus.mem_ready = 1'b0;
    #1;
    check_out("final_fetch_stall", exp_out("F", 1'b0, 1'b0, 3'd0));
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled store.
    bus.op = 6'd43;
    bus.mem_ready = 1'b1;
    #1;
    check_out("sw_fetch", exp_out("F", 1'b1, 1'b0, 3'd0));
    repeat (3) begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
    end
    #1;
    check_out("sw_memwr_stall", exp_out("W", 1'b0, 1'b0, 3'd0));
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_mem_write", 32'(bus.mem_write), 32'd0);
    check_out("async_reset_outputs", exp_out("I", 1'b0, 1'b0, 3'd0));
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_val("rst2_cyc_cnt", cyc_cnt, 32'd0);
    check_val("rst2_instr_cnt", instr_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    check_out("held_reset_idle", exp_out("I", 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_out("restart_idle", exp_out("I", 1'b0, 1'b0, 3'd0));
    @(posedge clk);
    #1;
    check_out("restart_fetch", exp_out("F", 1'b0, 1'b0, 3'd0));

    // Five instructions back to back: 4+3+3+3+3 = 16 busy cycles.
    run_vec(0);
    run_vec(2);
    run_vec(4);
    run_vec(5);
    run_vec(14);
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_val("perf_instr_cnt", instr_cnt, 32'd5);
    check_val("perf_cyc_cnt", cyc_cnt, 32'd16);
`endif
    bus.mem_ready = 1'b0;
    #1;
    check_out("end_fetch", exp_out("F", 1'b0, 1'b0, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
